uart_rx_monitor: RTL
====================

Name: uart_rx_monitor

Overview:
- Synthesizable 8N1 UART receiver that consumes the management SoC `ser_tx` line and decodes it into bytes for a bench or on-chip checker.
- Decoded bytes are buffered in a small show-ahead FIFO and drained with a valid/ready handshake.
- Reports framing errors, FIFO overrun, end-of-line (0x0A) and a saturating count of accepted bytes.

Parameters:
- CLKS_PER_BIT, 4167, core_clk cycles per UART bit (40 MHz / 9600 baud); legal range 4..65535.
- FIFO_DEPTH, 8, entries in the byte FIFO; must be a power of two, 2..64.
- EOL_CHAR, 8'h0A, byte value that raises eol_seen.

Ports:
- core_clk  in  1  system clock; all logic is on its rising edge.
- core_rst  in  1  asynchronous, active-high reset.
- ser_rx  in  1  serial input; asynchronous to core_clk; idle high.
- rx_data  out  8  head-of-FIFO byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO is non-empty.
- rx_ready  in  1  consumer accepts the head byte; pop happens when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full; cleared by clr_status.
- eol_seen  out  1  one-cycle pulse when EOL_CHAR is pushed into the FIFO.
- byte_count  out  16  bytes pushed since reset or clr_status; saturates at 16'hFFFF.
- clr_status  in  1  synchronous clear of overrun and byte_count.
- busy  out  1  receiver FSM is not in IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, eol_seen=0, byte_count=0, busy=0; FSM in IDLE; synchronizer flops = 1; FIFO empty.
- Input path: 2-flop synchronizer on ser_rx, giving 2-cycle latency; the FSM sees only rx_s.
- Bit-timer counter: 16 bits wide; it reloads on each state entry.
- IDLE: waits for rx_s=0, then enters START and clears the counter.
- START: waits CLKS_PER_BIT/2 cycles (integer division), then samples rx_s.
  - rx_s=0: enter DATA, bit index = 0.
  - rx_s=1: glitch; return to IDLE with no flags raised.
- DATA: samples rx_s every CLKS_PER_BIT cycles into the shift register, LSB first; after bit index 7 is sampled, enter STOP.
- STOP: samples rx_s after CLKS_PER_BIT cycles.
  - rx_s=1: push the byte; return to IDLE.
  - rx_s=0: frame_err pulses on the next cycle; the byte is discarded; enter WAIT_HIGH.
- WAIT_HIGH: stays until rx_s=1, then enters IDLE. This prevents a break condition from being decoded as repeated 0x00 bytes.
- Push timing: the push is registered, so rx_valid rises on the cycle after the stop-bit sample when the FIFO was empty.
- Byte side effects on push:
  - byte_count increments unless saturated.
  - eol_seen pulses in the same cycle as the push if the byte equals EOL_CHAR.
- FIFO full at push time:
  - Byte is dropped and overrun sets.
  - Exception: if a pop occurs in the same cycle, the push succeeds and overrun stays unchanged.
- FIFO is show-ahead: rx_data is the head entry combinationally from registered storage. Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Pop when empty: ignored.
- Simultaneous push and pop when empty: rx_valid goes high next cycle (no bypass).
- clr_status in the same cycle as a push: clear wins for overrun; byte_count becomes 1.
- busy = (state != IDLE).
- Reset mid-frame: everything returns to reset values immediately. A partially received byte is lost; no frame_err is raised.

Decomposition:
- Package uart_mon_pkg holds:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH};
  - localparam HALF_BIT = CLKS_PER_BIT/2;
  - byte_t typedef.
- Sub-module uart_rx_fifo (parameter DEPTH) contains the storage, pointers, full/empty and the push/pop arbitration. The top contains the synchronizer, FSM, counters and status.

Test Plan:
- Benches run with CLKS_PER_BIT=16.
- Send 0x55 then 0xA3 (8N1) with rx_ready=1 → two accepts, rx_data 0x55 then 0xA3, byte_count=2, frame_err never set.
- Send "OK\n" (0x4F, 0x4B, 0x0A) with rx_ready=0 → rx_valid=1, FIFO holds 3 entries, eol_seen pulses exactly once on the 0x0A push, byte_count=3.
- With rx_ready=0, send 9 bytes 0x00..0x08 → overrun=1 after the 9th byte, byte_count=8; then drain, which yields 0x00..0x07. Pulse clr_status → overrun=0, byte_count=0.
- 5-cycle low glitch on ser_rx → FSM returns to IDLE, no push, busy drops within HALF_BIT+3 cycles.
- Frame with stop bit held low for 40 bit times, then a normal 0x7E → frame_err pulses once, no 0x00 push, then 0x7E is received correctly.
- Assert core_rst during bit 4 of a frame, release, then send 0x31 → all outputs at reset values during reset; only 0x31 is received afterwards.

Source files
------------

// File: rtl/uart_mon_pkg.sv
// Shared types and constants for the UART receive monitor.
// Holds the receiver state encoding, the byte type and the half-bit helper.
package uart_mon_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 4167;
    localparam int unsigned HALF_BIT         = CLKS_PER_BIT_DEF / 2;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    function automatic logic [15:0] half_bit(input int unsigned cpb);
        return 16'(cpb / 2);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO with extra-MSB pointers; a push into a full FIFO
// is still accepted when a pop retires the head in the same cycle.
module uart_rx_fifo
    import uart_mon_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic  core_clk,
    input  logic  core_rst,
    input  logic  push,
    input  byte_t wr_data,
    input  logic  pop,
    output byte_t rd_data,
    output logic  rd_valid,
    output logic  push_ok
);

    localparam int unsigned AW = $clog2(DEPTH);

    byte_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver for the SoC ser_tx line: synchronizer, bit FSM,
// status counters and a show-ahead byte FIFO drained by valid/ready.
module uart_rx_monitor
    import uart_mon_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4167,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter byte_t       EOL_CHAR     = 8'h0A
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        ser_rx,
    output byte_t       rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        eol_seen,
    output logic [15:0] byte_count,
    input  logic        clr_status,
    output logic        busy,
    output state_t      state_dbg
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = half_bit(CLKS_PER_BIT) - 16'd1;

    logic        rx_meta;
    logic        rx_s;
    state_t      state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    byte_t       shreg;
    logic        bit_done;
    logic        push;
    logic        push_ok;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rx_s    <= rx_meta;
        end
    end

    assign bit_done = (bit_cnt == BIT_LAST);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not restart a frame until it idles high.
                    if (rx_s) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push      = (state == STOP) && bit_done && rx_s;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign eol_seen  = push_ok && (shreg == EOL_CHAR);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            overrun    <= 1'b0;
            byte_count <= '0;
        end else if (clr_status) begin
            overrun    <= 1'b0;
            byte_count <= push_ok ? 16'd1 : 16'd0;
        end else begin
            if (push && !push_ok) begin
                overrun <= 1'b1;
            end
            if (push_ok && byte_count != 16'hFFFF) begin
                byte_count <= byte_count + 16'd1;
            end
        end
    end

    // rx_valid/rx_ready: rx_data is stable while rx_valid is high and the head
    // byte is consumed on any rising edge where both are high.
    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .core_clk(core_clk),
        .core_rst(core_rst),
        .push    (push),
        .wr_data (shreg),
        .pop     (rx_ready),
        .rd_data (rx_data),
        .rd_valid(rx_valid),
        .push_ok (push_ok)
    );

endmodule
